// File: rtl/fx_pkg.sv
// fx_pkg: shared constants and FSM state type for the effect path.
// Provides NOTE_W, NOTE_MAX and the portamento state enum.
package fx_pkg;

    localparam int NOTE_W   = 6;
    localparam int NOTE_MAX = (1 << NOTE_W) - 1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_IDLE,
        ST_LOAD,
        ST_GLIDE
    } state_t;

endpackage

// File: rtl/fx_tick_gen.sv
// fx_tick_gen: free-running glide-rate prescaler, one-cycle tick out.
// Ports: clk50mhz, reset (sync, high), glide_rate (FX_PORTA_RATE_EN), tick.
module fx_tick_gen #(
    parameter int TICK_DIV = 10000
) (
    input  logic       clk50mhz,
    input  logic       reset,
`ifdef FX_PORTA_RATE_EN
    input  logic [2:0] glide_rate,
`endif
    output logic       tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == LAST);

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

`ifdef FX_PORTA_RATE_EN
    // Stretch the tick by counting whole prescaler periods; the rate is
    // only picked up at a wrap so a mid-period change never shortens one.
    logic [2:0] rate_q;
    logic [2:0] rate_cnt;
    logic       rate_hit;

    assign rate_hit = (rate_cnt >= rate_q);
    assign tick     = wrap & rate_hit;

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            rate_q   <= '0;
            rate_cnt <= '0;
        end else if (wrap) begin
            rate_q <= glide_rate;
            if (rate_hit) begin
                rate_cnt <= '0;
            end else begin
                rate_cnt <= rate_cnt + 3'd1;
            end
        end
    end
`else
    assign tick = wrap;
`endif

endmodule

// File: rtl/fx_porta_ctrl.sv
// fx_porta_ctrl: portamento sequencer, glides note_out toward note_in.
// Ports: clk50mhz, reset, en, note_in/note_valid/note_ready (handshake),
//        note_out, busy, glide_done; glide_rate when FX_PORTA_RATE_EN.
module fx_porta_ctrl #(
    parameter int NOTE_W   = fx_pkg::NOTE_W,
    parameter int TICK_DIV = 10000,
    parameter int STEPS    = 4
) (
    input  logic              clk50mhz,
    input  logic              reset,
    input  logic              en,
    input  logic [NOTE_W-1:0] note_in,
    input  logic              note_valid,
`ifdef FX_PORTA_RATE_EN
    input  logic [2:0]        glide_rate,
`endif
    output logic              note_ready,
    output logic [NOTE_W-1:0] note_out,
    output logic              busy,
    output logic              glide_done
);

    import fx_pkg::*;

    state_t            state;
    state_t            state_nx;
    logic              tick;
    logic              accept;
    logic              first;
    logic              dir_up;
    logic              up;
    logic [NOTE_W-1:0] target;
    logic [NOTE_W-1:0] step;
    logic [NOTE_W-1:0] diff;
    logic [NOTE_W-1:0] quo;
    logic [NOTE_W-1:0] step_calc;
    logic              arrive;

    fx_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk50mhz   (clk50mhz),
        .reset      (reset),
`ifdef FX_PORTA_RATE_EN
        .glide_rate (glide_rate),
`endif
        .tick       (tick)
    );

    assign accept = note_valid & note_ready;

    // Distance to target, shared by LOAD (step sizing) and GLIDE.
    assign up        = (target > note_out);
    assign diff      = up ? (target - note_out) : (note_out - target);
    assign quo       = NOTE_W'(int'(diff) / STEPS);
    assign step_calc = ((quo == '0) && (diff != '0)) ? NOTE_W'(1) : quo;
    assign arrive    = (diff <= step);

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            state <= ST_OFF;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = ST_OFF;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_nx = ST_IDLE;
                end
                ST_IDLE: begin
                    if (accept && !first) begin
                        state_nx = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_nx = (diff == '0) ? ST_IDLE : ST_GLIDE;
                end
                ST_GLIDE: begin
                    if (accept) begin
                        state_nx = ST_LOAD;
                    end else if (tick && arrive) begin
                        state_nx = ST_IDLE;
                    end
                end
                default: begin
                    state_nx = ST_OFF;
                end
            endcase
        end
    end

    always_comb begin
        note_ready = en & ((state == ST_IDLE) | (state == ST_GLIDE));
        busy       = (state == ST_LOAD) | (state == ST_GLIDE);
    end

    // Datapath: note_out, target, step size and the done pulse.
    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            note_out   <= '0;
            target     <= '0;
            step       <= '0;
            dir_up     <= 1'b0;
            first      <= 1'b1;
            glide_done <= 1'b0;
        end else begin
            glide_done <= 1'b0;
            if (!en) begin
                note_out <= '0;
                target   <= '0;
                first    <= 1'b1;
            end else begin
                unique case (state)
                    ST_OFF: begin
                        first <= 1'b1;
                    end
                    ST_IDLE: begin
                        if (accept) begin
                            if (first) begin
                                note_out <= note_in;
                                first    <= 1'b0;
                            end else begin
                                target <= note_in;
                            end
                        end
                    end
                    ST_LOAD: begin
                        step   <= step_calc;
                        dir_up <= up;
                        if (diff == '0) begin
                            glide_done <= 1'b1;
                        end
                    end
                    ST_GLIDE: begin
                        // A retarget beats a coincident tick.
                        if (accept) begin
                            target <= note_in;
                        end else if (tick) begin
                            if (arrive) begin
                                note_out   <= target;
                                glide_done <= 1'b1;
                            end else if (dir_up) begin
                                note_out <= note_out + step;
                            end else begin
                                note_out <= note_out - step;
                            end
                        end
                    end
                    default: begin
                        note_out <= '0;
                    end
                endcase
            end
        end
    end

endmodule
